// File: rtl/kfc_pkg.sv
// Shared constants for the kernel weight fetch sequencer: state encoding,
// default geometry and the output buffer depth rule.
package kfc_pkg;

   // state | meaning
   // IDLE  | waiting for a run request
   // FETCH | issuing BRAM reads across the address window
   // DRAIN | reads all issued, waiting for downstream to take the rest
   // DONE  | single-cycle completion pulse
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int KFC_KW     = 5;
   localparam int KFC_KH     = 5;
   localparam int KFC_D_BW   = 8;
   localparam int KFC_AWIDTH = 6;
   localparam int KFC_RD_LAT = 1;
   localparam int KFC_DEPTH  = KFC_RD_LAT + 1;
   localparam int KFC_DWIDTH = KFC_KW * KFC_KH * KFC_D_BW;

   // One slot per in-flight read plus one for the word being presented.
   function automatic int kfc_depth(input int rd_lat);
      return rd_lat + 1;
   endfunction

endpackage

// File: rtl/kfc_out_fifo.sv
// Small synchronous output buffer between the BRAM read port and the
// downstream valid/ready interface. Head word is shown combinationally.
module kfc_out_fifo
   import kfc_pkg::*;
#(
   parameter int WIDTH = KFC_DWIDTH,
   parameter int DEPTH = KFC_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign rdata = mem[rd_ptr];
   assign empty = (count == '0);

   // Storage, pointers and occupancy; a push into a full buffer is only
   // ever paired with a pop, so the head slot is reused safely.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/kernel_fetch_ctrl.sv
// Kernel weight fetch sequencer: sweeps a BRAM address window on a run
// command and streams the returned words downstream with backpressure.
module kernel_fetch_ctrl
   import kfc_pkg::*;
#(
   parameter int KW     = KFC_KW,
   parameter int KH     = KFC_KH,
   parameter int D_BW   = KFC_D_BW,
   parameter int AWIDTH = KFC_AWIDTH,
   parameter int RD_LAT = KFC_RD_LAT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_run,
   input  logic [AWIDTH-1:0]      i_base,
   input  logic [AWIDTH:0]        i_len,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   bram_en,
   output logic [AWIDTH-1:0]      bram_addr,
   input  logic [KW*KH*D_BW-1:0]  bram_rdata,
   output logic                   o_valid,
   output logic [KW*KH*D_BW-1:0]  o_data,
   input  logic                   i_ready
);

   localparam int DW    = KW * KH * D_BW;
   localparam int DEPTH = kfc_depth(RD_LAT);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int SW    = CW + 1;
   localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH+1)'(1);

   logic [1:0]        state;
   logic [AWIDTH-1:0] base_q;
   logic [AWIDTH-1:0] last_addr;
   logic [AWIDTH-1:0] next_addr;
   logic [AWIDTH:0]   len_q;
   logic [AWIDTH:0]   issued_cnt;
   logic [AWIDTH:0]   accepted_cnt;
   logic [RD_LAT-1:0] inflight_sr;
   logic [SW-1:0]     inflight_n;
   logic [SW-1:0]     occupancy;
   logic [CW-1:0]     fifo_count;
   logic              fifo_empty;
   logic              pop;
   logic              push;
   logic              credit;
   logic              issue;

   assign pop       = o_valid & i_ready;
   assign push      = inflight_sr[RD_LAT-1];
   assign o_valid   = !fifo_empty;
   assign next_addr = base_q + issued_cnt[AWIDTH-1:0];

   // Number of reads still travelling through the BRAM pipeline.
   always_comb begin
      inflight_n = '0;
      for (int i = 0; i < RD_LAT; i++) inflight_n = inflight_n + SW'(inflight_sr[i]);
   end

   // A word leaving this cycle frees its slot immediately, which is what
   // sustains one read per cycle when downstream never stalls.
   assign occupancy = SW'(fifo_count) + inflight_n;
   assign credit    = (occupancy - SW'(pop)) < SW'(DEPTH);
   assign issue     = (state == ST_FETCH) && credit;

   assign bram_en   = issue;
   assign bram_addr = issue ? next_addr : last_addr;
   assign o_busy    = (state == ST_FETCH) || (state == ST_DRAIN);
   assign o_done    = (state == ST_DONE);

   // Sequencer state, captured window and issue/accept counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         base_q       <= '0;
         len_q        <= '0;
         issued_cnt   <= '0;
         accepted_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_run) begin
                  base_q       <= i_base;
                  len_q        <= i_len;
                  issued_cnt   <= '0;
                  accepted_cnt <= '0;
                  state        <= (i_len == '0) ? ST_DONE : ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (issue && (issued_cnt + CNT_ONE == len_q)) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (pop && (accepted_cnt + CNT_ONE == len_q)) state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
         if (issue) issued_cnt   <= issued_cnt + CNT_ONE;
         if (pop)   accepted_cnt <= accepted_cnt + CNT_ONE;
      end
   end

   // Read-enable delay line marking when BRAM data lands, plus the held address.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight_sr <= '0;
         last_addr   <= '0;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) inflight_sr[i] <= inflight_sr[i-1];
         inflight_sr[0] <= issue;
         if (issue) last_addr <= next_addr;
      end
   end

   kfc_out_fifo #(
      .WIDTH (DW),
      .DEPTH (DEPTH)
   ) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (bram_rdata),
      .pop   (pop),
      .rdata (o_data),
      .count (fifo_count),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_kernel_fetch_ctrl.sv
// Bench for kernel_fetch_ctrl: table of run vectors plus randomized runs,
// scored against an expected word queue built from the BRAM contents.
module tb_kernel_fetch_ctrl;

   localparam int KW     = 5;
   localparam int KH     = 5;
   localparam int D_BW   = 8;
   localparam int AWIDTH = 6;
   localparam int RD_LAT = 1;
   localparam int DW     = KW * KH * D_BW;
   localparam int DEPTH  = RD_LAT + 1;
   localparam int NWORDS = 1 << AWIDTH;

   logic              clk;
   logic              rst;
   logic              i_run;
   logic [AWIDTH-1:0] i_base;
   logic [AWIDTH:0]   i_len;
   logic              o_busy;
   logic              o_done;
   logic              bram_en;
   logic [AWIDTH-1:0] bram_addr;
   logic [DW-1:0]     bram_rdata;
   logic              o_valid;
   logic [DW-1:0]     o_data;
   logic              i_ready;

   kernel_fetch_ctrl #(
      .KW(KW), .KH(KH), .D_BW(D_BW), .AWIDTH(AWIDTH), .RD_LAT(RD_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_run      (i_run),
      .i_base     (i_base),
      .i_len      (i_len),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .bram_en    (bram_en),
      .bram_addr  (bram_addr),
      .bram_rdata (bram_rdata),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .i_ready    (i_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model: data for an enabled read appears RD_LAT cycles later.
   logic [DW-1:0] mem     [NWORDS];
   logic [DW-1:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      if (bram_en) rd_pipe[0] <= mem[bram_addr];
   end
   assign bram_rdata = rd_pipe[RD_LAT-1];

   // mode: 0 ready high, 1 alternate 1/0, 2 random, 3 stall six cycles at first valid
   typedef struct {
      logic [AWIDTH-1:0] base;
      logic [AWIDTH:0]   len;
      int                mode;
      bit                pulse;
      int                exp_done;
      int                exp_first_en;
      int                exp_first_valid;
      int                exp_max_out;
   } vec_t;

   vec_t        tbl [5];
   vec_t        rv;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          seen;
   logic [4:0]  b2b_pat;

   task automatic chk_eq(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chk_true(input string name, input bit ok, input longint act, input longint lim);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d limit %0d", name, act, lim);
   endtask

   task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_reset(input string tag);
      chk_eq({tag, "_busy"},  o_busy,    0);
      chk_eq({tag, "_done"},  o_done,    0);
      chk_eq({tag, "_en"},    bram_en,   0);
      chk_eq({tag, "_addr"},  bram_addr, 0);
      chk_eq({tag, "_valid"}, o_valid,   0);
      chk_data({tag, "_data"}, o_data, '0);
   endtask

   function automatic bit ready_for(input int mode, input int k);
      case (mode)
         1:       return (k % 2) == 0;
         2:       return $urandom_range(0, 3) != 0;
         3:       return !(k >= RD_LAT + 2 && k < RD_LAT + 8);
         default: return 1'b1;
      endcase
   endfunction

   // Launch one run at the current cycle (T) and score it to completion.
   task automatic run_vec(input vec_t v, input string tag);
      logic [DW-1:0] exp_q [$];
      logic [DW-1:0] held_data;
      bit            held;
      bit            finished;
      int k, issued, accepted, done_cnt, done_k, last_hs_k;
      int first_en_k, first_valid_k, last_en_k, max_out, busy_seen;

      for (int i = 0; i < int'(v.len); i++) exp_q.push_back(mem[(int'(v.base) + i) % NWORDS]);
      issued = 0; accepted = 0; done_cnt = 0; done_k = -1; last_hs_k = -1;
      first_en_k = -1; first_valid_k = -1; last_en_k = -1; max_out = 0; busy_seen = 0;
      held = 1'b0; held_data = '0; finished = 1'b0;

      i_base  = v.base;
      i_len   = v.len;
      i_run   = 1'b1;
      i_ready = ready_for(v.mode, 0);
      k = 0;
      while (!finished) begin
         @(negedge clk);
         if (bram_en) begin
            issued++;
            chk_eq({tag, "_addr"}, bram_addr, (int'(v.base) + issued - 1) % NWORDS);
            chk_true({tag, "_issue_bound"}, issued <= int'(v.len), issued, v.len);
            if (first_en_k < 0) first_en_k = k;
            last_en_k = k;
         end
         if (held) begin
            chk_eq({tag, "_valid_held"}, o_valid, 1);
            chk_data({tag, "_data_stable"}, o_data, held_data);
         end
         if (o_valid && first_valid_k < 0) first_valid_k = k;
         if (o_valid && i_ready) begin
            chk_true({tag, "_word_expected"}, exp_q.size() > 0, accepted, v.len);
            if (exp_q.size() > 0) chk_data({tag, "_data"}, o_data, exp_q.pop_front());
            accepted++;
            last_hs_k = k;
         end
         held      = o_valid && !i_ready;
         held_data = o_data;
         if (issued - accepted > max_out) max_out = issued - accepted;
         if (o_busy) busy_seen = 1;
         if (o_done) begin
            done_cnt++;
            done_k = k;
            chk_eq({tag, "_busy_at_done"}, o_busy, 0);
         end
         @(posedge clk);
         #1;
         k++;
         i_run   = v.pulse && (k == 10 || k == 11);
         i_base  = AWIDTH'($urandom);
         i_len   = (AWIDTH+1)'($urandom);
         i_ready = ready_for(v.mode, k);
         if (done_cnt > 0 && k >= done_k + 3) finished = 1'b1;
         if (k > 400) begin
            chk_true({tag, "_timeout"}, 1'b0, k, 400);
            finished = 1'b1;
         end
      end
      i_ready = 1'b1;

      chk_eq({tag, "_done_count"},  done_cnt, 1);
      chk_eq({tag, "_issued"},      issued, v.len);
      chk_eq({tag, "_accepted"},    accepted, v.len);
      chk_eq({tag, "_left_over"},   exp_q.size(), 0);
      chk_eq({tag, "_first_en"},    first_en_k, v.exp_first_en);
      chk_eq({tag, "_first_valid"}, first_valid_k, v.exp_first_valid);
      chk_true({tag, "_max_out"}, max_out <= DEPTH, max_out, DEPTH);
      if (v.exp_done >= 0)    chk_eq({tag, "_done_k"}, done_k, v.exp_done);
      if (v.exp_max_out >= 0) chk_eq({tag, "_max_out_eq"}, max_out, v.exp_max_out);
      if (v.len == 0) chk_eq({tag, "_busy_seen"}, busy_seen, 0);
      else            chk_eq({tag, "_done_after_hs"}, done_k, last_hs_k + 1);
      if (v.mode == 0 && v.len != 0) chk_eq({tag, "_last_en"}, last_en_k, v.len);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
      $fatal(1);
   end

   initial begin
      rst     = 1'b0;
      i_run   = 1'b0;
      i_ready = 1'b1;
      i_base  = '0;
      i_len   = '0;
      for (int a = 0; a < NWORDS; a++)
         mem[a] = {32'($urandom), 32'($urandom), 32'($urandom),
                   32'($urandom), 32'($urandom), 32'($urandom), 8'(a + 100)};
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;

      repeat (3) @(posedge clk);
      #1;
      chk_reset("por");
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;

      //            base    len    mode pulse done first_en first_valid max_out
      tbl[0] = '{6'd0,  7'd4,  0, 1'b0,  7, 1,  3, -1};
      tbl[1] = '{6'd62, 7'd4,  0, 1'b0,  7, 1,  3, -1};
      tbl[2] = '{6'd0,  7'd0,  0, 1'b0,  1, -1, -1, -1};
      tbl[3] = '{6'd0,  7'd8,  3, 1'b0, -1, 1,  3,  2};
      tbl[4] = '{6'd0,  7'd64, 1, 1'b1, -1, 1,  3, -1};
      for (int t = 0; t < 5; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

      // i_run held through DONE: second request taken only in the next IDLE
      b2b_pat = 5'b01010;
      i_base  = '0;
      i_len   = '0;
      i_run   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk_eq($sformatf("b2b_done_k%0d", k), o_done, b2b_pat[k]);
         chk_eq($sformatf("b2b_busy_k%0d", k), o_busy, 0);
         @(posedge clk);
         #1;
         if (k == 2) i_run = 1'b0;
      end
      i_run = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // reset in the middle of FETCH, then a clean run must see no stale words
      i_base = 6'd5;
      i_len  = 7'd20;
      i_run  = 1'b1;
      seen   = 0;
      for (int k = 0; k < 20 && seen < 3; k++) begin
         @(negedge clk);
         if (bram_en) seen++;
         if (seen < 3) begin
            @(posedge clk);
            #1;
            i_run = 1'b0;
         end
      end
      chk_eq("rst_issues_seen", seen, 3);
      i_run = 1'b0;
      #2 rst = 1'b0;
      #1 chk_reset("rst_async");
      @(posedge clk);
      #1 chk_reset("rst_next");
      @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      rv = '{6'd10, 7'd2, 0, 1'b0, 2 + RD_LAT + 2, 1, RD_LAT + 2, -1};
      run_vec(rv, "post_rst");

      // randomized windows and lengths
      for (int r = 0; r < 6; r++) begin
         rv.base            = AWIDTH'($urandom_range(0, NWORDS - 1));
         rv.len             = (AWIDTH+1)'($urandom_range(1, NWORDS));
         rv.mode            = (r < 2) ? 0 : 2;
         rv.pulse           = (r == 3);
         rv.exp_done        = (rv.mode == 0) ? int'(rv.len) + RD_LAT + 2 : -1;
         rv.exp_first_en    = 1;
         rv.exp_first_valid = RD_LAT + 2;
         rv.exp_max_out     = -1;
         run_vec(rv, $sformatf("rnd%0d", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/kernel_fetch_ctrl.md
# kernel_fetch_ctrl

Sequencer that drives the kernel weight BRAM on behalf of the data mover. On a run command it sweeps a programmable address window, tracks BRAM read latency, buffers returned words and presents them downstream under a valid/ready handshake with full backpressure. It sits between the accelerator control path (run/base/length) and the BRAM read port, and feeds the data mover's kernel input.

## Interface
- KW, 5, kernel width
- KH, 5, kernel height
- D_BW, 8, bits per kernel element
- AWIDTH, 6, BRAM address width
- RD_LAT, 1, BRAM read latency in cycles (legal: 1, 2)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_run  in  1  start request, sampled only in IDLE
- i_base  in  AWIDTH  first address, captured on accepted i_run
- i_len  in  AWIDTH+1  words to fetch, 0..2^AWIDTH, captured on accepted i_run
- o_busy  out  1  high in FETCH and DRAIN
- o_done  out  1  one-cycle completion pulse
- bram_en  out  1  BRAM read enable
- bram_addr  out  AWIDTH  BRAM read address
- bram_rdata  in  KW*KH*D_BW  BRAM read data, valid RD_LAT cycles after bram_en
- o_valid  out  1  downstream word valid
- o_data  out  KW*KH*D_BW  downstream word
- i_ready  in  1  downstream ready

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: i_run=1 captures i_base/i_len; i_len=0 -> DONE, else -> FETCH. i_run in any other state ignored.
- FETCH: issue one read per cycle while credit available; bram_addr = (base + issued_cnt) mod 2^AWIDTH (wrap 2^AWIDTH-1 -> 0). After i_len-th issue -> DRAIN.
- DRAIN: no issues; wait until all words accepted downstream (last o_valid&i_ready) -> DONE.
- DONE: o_done=1 for one cycle -> IDLE.
- Output buffer FIFO, DEPTH = RD_LAT+1. Every issued read is written into FIFO exactly RD_LAT cycles later (in-flight shift register of enables).
- Credit rule: issue allowed when fifo_count + inflight - pop < DEPTH, pop = o_valid&i_ready this cycle. Guarantees no overflow and 1 word/cycle when i_ready held high.
- bram_en=0 whenever not issuing; bram_addr holds last value when idle.
- o_valid = FIFO non-empty; o_data = FIFO head, stable while o_valid&!i_ready.
- Counters: issued_cnt and accepted_cnt each AWIDTH+1 bits; compared to captured length.
- Reset mid-operation: FSM -> IDLE, counters/FIFO/in-flight cleared; data arriving from BRAM after reset deassertion discarded.

## Timing
- Reset values: o_busy=0, o_done=0, bram_en=0, bram_addr=0, o_valid=0, o_data=0.
- i_run accepted in cycle T -> first bram_en in T+1 (addr=base).
- Read data written to FIFO at end of cycle T+1+RD_LAT; first o_valid in T+2+RD_LAT.
- Steady state with i_ready=1: one bram_en and one o_valid per cycle.
- o_done in the cycle after the final handshake; o_busy low in that same cycle.
- i_len=0: o_done at T+1, no bram_en, o_busy stays 0.
- Back-to-back: i_run asserted during DONE ignored; next accepted in following IDLE cycle.

## Structure
- Package kfc_pkg: state enum encoding (IDLE/FETCH/DRAIN/DONE), localparam DEPTH = RD_LAT+1, data width localparam KW*KH*D_BW.
- One sub-module: kfc_out_fifo (synchronous FIFO, parameterised width/depth, count output, async active-low reset).
- Controller holds FSM, counters, address adder, in-flight shift register and credit logic.

## Test plan
- RD_LAT=1, base=0, len=4, i_ready=1, mem[a]=a+100 -> bram_en T+1..T+4 addr 0..3; o_valid T+3..T+6 data 100..103; o_done T+7 only.
- base=62, len=4 -> addresses 62,63,0,1; data order matches; single o_done.
- len=0 -> no bram_en, no o_valid, o_done at T+1, o_busy never high.
- len=8, i_ready low 6 cycles after first o_valid -> bram_en stops once 2 words held/in flight, o_data held stable, all 8 words delivered in order after i_ready returns, no duplicates.
- len=64, i_ready pattern 1,0,1,0 -> 64 words addr 0..63 in order, o_done once; i_run pulsed mid-run ignored.
- Reset asserted in FETCH after 3 issues -> all outputs at reset values next cycle; new run base=10, len=2 delivers mem[10], mem[11] with no stale words.
